// File: rtl/uart_peek_sched.sv
// rtl/uart_peek_sched.sv - host-directed peek scheduler between uart bytes and the NoC peek port
// Define PEEK_CHECKSUM_EN to append an XOR checksum byte after each returned word.
module uart_peek_sched #(
  parameter int NUM_CORES      = 16,
  parameter int PEEK_LAT       = 1,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int ID_W          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [ID_W-1:0] peek_id,
  output logic [31:0]     peek_address,
  input  logic [31:0]     peek_data,
  output logic            busy,
  output logic            rx_overrun
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      WAIT_LAST = 3'(PEEK_LAT - 1);
  localparam logic [31:0]     NC        = NUM_CORES;
`ifdef PEEK_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ID, S_LEN, S_ISSUE, S_WAIT, S_SEND, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic              burst_q, burst_d;
  logic [31:0]       addr_sh_q, addr_sh_d;
  logic [ID_W-1:0]   id_sh_q, id_sh_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [8:0]        count_q, count_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        err_q, err_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic [ID_W-1:0]   peek_id_q, peek_id_d;
  logic [31:0]       peek_addr_q, peek_addr_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        send_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      burst_q     <= 1'b0;
      addr_sh_q   <= '0;
      id_sh_q     <= '0;
      byte_cnt_q  <= '0;
      count_q     <= '0;
      wait_cnt_q  <= '0;
      word_q      <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      idle_q      <= '0;
      peek_id_q   <= '0;
      peek_addr_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      addr_sh_q   <= addr_sh_d;
      id_sh_q     <= id_sh_d;
      byte_cnt_q  <= byte_cnt_d;
      count_q     <= count_d;
      wait_cnt_q  <= wait_cnt_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      idle_q      <= idle_d;
      peek_id_q   <= peek_id_d;
      peek_addr_q <= peek_addr_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef PEEK_CHECKSUM_EN
  assign send_byte = (idx_q == 3'd4) ?
                     (word_q[7:0] ^ word_q[15:8] ^ word_q[23:16] ^ word_q[31:24]) :
                     word_q[8*idx_q[1:0] +: 8];
`else
  assign send_byte = word_q[8*idx_q[1:0] +: 8];
`endif

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    addr_sh_d   = addr_sh_q;
    id_sh_d     = id_sh_q;
    byte_cnt_d  = byte_cnt_q;
    count_d     = count_q;
    wait_cnt_d  = wait_cnt_q;
    word_d      = word_q;
    idx_d       = idx_q;
    err_d       = err_q;
    idle_d      = '0;
    peek_id_d   = peek_id_q;
    peek_addr_d = peek_addr_q;
    overrun_d   = overrun_q;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'h01 || rx_data == 8'h02) begin
            burst_d    = rx_data[1];
            byte_cnt_d = 2'd0;
            state_d    = S_ADDR;
          end else begin
            err_d   = 8'hE0;
            state_d = S_ERR;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_sh_d[8*byte_cnt_q +: 8] = rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_ID;
        end
      end
      S_ID: begin
        if (rx_valid) begin
          if ({24'd0, rx_data} >= NC) begin
            err_d   = 8'hE1;
            state_d = S_ERR;
          end else begin
            id_sh_d = rx_data[ID_W-1:0];
            if (burst_q) begin
              state_d = S_LEN;
            end else begin
              count_d = 9'd1;
              state_d = S_ISSUE;
            end
          end
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          count_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        peek_id_d   = id_sh_q;
        peek_addr_d = addr_sh_q;
        wait_cnt_d  = 3'd0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          word_d  = peek_data;
          idx_d   = 3'd0;
          state_d = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = send_byte;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            count_d = count_q - 9'd1;
            if (count_q == 9'd1) begin
              state_d = S_IDLE;
            end else begin
              addr_sh_d = addr_sh_q + 32'd1;
              state_d   = S_ISSUE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_ERR: begin
        tx_valid = 1'b1;
        tx_data  = err_q;
        if (tx_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout only applies while a frame is partially received.
    if (state_q == S_ADDR || state_q == S_ID || state_q == S_LEN) begin
      if (rx_valid) begin
        idle_d = '0;
      end else if (idle_q == TO_LAST) begin
        state_d = S_IDLE;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    if (rx_valid && (state_q == S_ISSUE || state_q == S_WAIT ||
                     state_q == S_SEND  || state_q == S_ERR)) begin
      overrun_d = 1'b1;
    end
  end

  assign peek_id      = peek_id_q;
  assign peek_address = peek_addr_q;
  assign busy         = (state_q != S_IDLE);
  assign rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_peek_sched.sv
// tb/tb_uart_peek_sched.sv - self-checking bench for uart_peek_sched
// Honours PEEK_CHECKSUM_EN to expect the per-word checksum byte.
module tb_uart_peek_sched;

  localparam int NUM_CORES = 16;
  localparam int PEEK_LAT  = 2;
  localparam int TIMEOUT   = 200;
`ifdef PEEK_CHECKSUM_EN
  localparam int BPW = 5;
`else
  localparam int BPW = 4;
`endif

  logic        clk, rst;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, tx_valid, tx_ready;
  logic [3:0]  peek_id;
  logic [31:0] peek_address, peek_data;
  logic        busy, rx_overrun;

  uart_peek_sched #(.NUM_CORES(NUM_CORES), .PEEK_LAT(PEEK_LAT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .peek_id(peek_id), .peek_address(peek_address), .peek_data(peek_data),
    .busy(busy), .rx_overrun(rx_overrun)
  );

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] noc_word(input logic [3:0] id, input logic [31:0] a);
    if (id == 4'd3 && a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ {id, 28'h0} ^ 32'h13579BDF;
  endfunction

  // NoC model with PEEK_LAT=2: data follows the address by one register stage.
  logic [31:0] pd_q;
  initial begin
    pd_q = '0;
    forever begin
      @(posedge clk);
      pd_q = noc_word(peek_id, peek_address);
    end
  end
  assign peek_data = pd_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic hold, bp_rand;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold) tx_ready = 1'b0;
      else if (bp_rand) tx_ready = ($urandom_range(0, 3) != 0);
      else tx_ready = 1'b1;
    end
  end

  logic [7:0]  got_b[$];
  logic [31:0] got_a[$];
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("tx_valid_held", tx_valid, 1'b1);
          check("tx_data_stable", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          got_b.push_back(tx_data);
          got_a.push_back(peek_address);
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  logic [7:0]  exp_b[$];
  logic [31:0] exp_a[$];
  logic [31:0] last_addr;
  logic [3:0]  last_id;

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("busy_returns_0", busy, 1'b0);
  endtask

  task automatic wait_got(input int cnt, input int budget);
    int n = 0;
    while (got_b.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_progress", 32'(got_b.size() >= cnt), 32'd1);
  endtask

  task automatic start_frame(input logic [7:0] op, input logic [31:0] addr,
                             input logic [3:0] id, input logic [7:0] len);
    int n;
    logic [31:0] a, d;
    n = (op == 8'h02) ? ((len == 8'h00) ? 256 : int'(len)) : 1;
    exp_b.delete();
    exp_a.delete();
    got_b.delete();
    got_a.delete();
    for (int w = 0; w < n; w++) begin
      a = addr + 32'(w);
      d = noc_word(id, a);
      for (int k = 0; k < 4; k++) begin
        exp_b.push_back(d[8*k +: 8]);
        exp_a.push_back(a);
      end
      if (BPW == 5) begin
        exp_b.push_back(d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]);
        exp_a.push_back(a);
      end
      last_addr = a;
    end
    last_id = id;
    send_byte(op);
    for (int k = 0; k < 4; k++) send_byte(addr[8*k +: 8]);
    send_byte({4'h0, id});
    if (op == 8'h02) send_byte(len);
  endtask

  task automatic finish_frame();
    int m;
    wait_idle(30000);
    check("byte_count", got_b.size(), exp_b.size());
    m = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < m; i++) begin
      check("tx_byte", got_b[i], exp_b[i]);
      check("byte_addr", got_a[i], exp_a[i]);
    end
    check("peek_address_hold", peek_address, last_addr);
    check("peek_id_hold", peek_id, last_id);
  endtask

  task automatic expect_err(input logic [7:0] code);
    wait_idle(1000);
    check("err_count", got_b.size(), 1);
    check("err_byte", (got_b.size() > 0) ? 32'(got_b[0]) : 32'h1FF, code);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; hold = 1'b0; bp_rand = 1'b0;
    last_addr = '0; last_id = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_peek_address", peek_address, 32'h0);
    check("rst_peek_id", peek_id, 4'h0);
    check("rst_overrun", rx_overrun, 1'b0);
    @(posedge clk); #1; rst = 1'b0;

    start_frame(8'h01, 32'h10, 4'd3, 8'h00);
    finish_frame();
    check("single_b0", (got_b.size() > 0) ? 32'(got_b[0]) : 32'h1FF, 8'hEF);
    check("single_b3", (got_b.size() > 3) ? 32'(got_b[3]) : 32'h1FF, 8'hDE);
    if (BPW == 5) check("single_ck", (got_b.size() > 4) ? 32'(got_b[4]) : 32'h1FF, 8'h22);
    check("single_addr", peek_address, 32'h10);
    check("single_id", peek_id, 4'd3);

    start_frame(8'h02, 32'hFFFFFFFE, 4'd1, 8'h03);
    finish_frame();
    check("wrap_first_addr", (got_a.size() > 0) ? got_a[0] : 32'hBAD, 32'hFFFFFFFE);
    check("wrap_last_addr", peek_address, 32'h0);

    start_frame(8'h02, 32'h00001000, 4'd7, 8'h00);
    finish_frame();
    check("len0_bytes", got_b.size(), 256 * BPW);

    start_frame(8'h02, 32'h200, 4'd9, 8'h02);
    wait_got(2, 500);
    hold = 1'b1;
    repeat (50) @(negedge clk);
    check("bp_valid", tx_valid, 1'b1);
    hold = 1'b0;
    finish_frame();

    got_b.delete();
    send_byte(8'h07);
    expect_err(8'hE0);
    got_b.delete();
    send_byte(8'h01);
    for (int k = 0; k < 4; k++) send_byte(8'h00);
    send_byte(8'h10);
    expect_err(8'hE1);
    check("e1_no_issue_addr", peek_address, last_addr);
    check("e1_no_issue_id", peek_id, last_id);

    got_b.delete();
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (TIMEOUT - 20) @(negedge clk);
    check("to_still_busy", busy, 1'b1);
    repeat (40) @(negedge clk);
    check("to_aborted", busy, 1'b0);
    check("to_no_tx", got_b.size(), 0);
    check("overrun_clear", rx_overrun, 1'b0);

    start_frame(8'h01, 32'h0BADF00D, 4'd12, 8'h00);
    finish_frame();

    start_frame(8'h02, 32'h40, 4'd5, 8'h02);
    wait_got(1, 500);
    send_byte(8'h55);
    finish_frame();
    check("overrun_set", rx_overrun, 1'b1);

    bp_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      logic [31:0] ra;
      ra = (r % 2 == 0) ? $urandom() : (32'hFFFFFFFF - 32'($urandom_range(0, 3)));
      start_frame(($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02, ra,
                  4'($urandom_range(0, NUM_CORES - 1)), 8'($urandom_range(1, 5)));
      finish_frame();
    end
    bp_rand = 1'b0;

    start_frame(8'h02, 32'h300, 4'd2, 8'h04);
    wait_got(BPW + 1, 1000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", peek_address, 32'h0);
    check("mid_rst_id", peek_id, 4'h0);
    check("mid_rst_overrun", rx_overrun, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    start_frame(8'h01, 32'h10, 4'd3, 8'h00);
    finish_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
